mmio_tone_mixer: RTL and testbench
==================================

# mmio_tone_mixer

Memory-mapped, multi-channel square-wave tone generator with a mixed PWM audio output. It sits on the processor data bus beside the switch and LED I/O words, and it replaces the single-frequency, divide-based tone path. The CPU writes a half-period count, a volume and a note duration per channel. Notes then play and stop on their own, so the CPU never busy-waits for note timing.

## Interface
Parameters:
- NUM_CH, 4, number of tone channels (1..8)
- SYS_FREQ, 50000000, `clock` frequency in Hz; sets the 1 ms tick prescaler
- DIV_W, 24, width of the half-period counter
- PWM_W, 10, PWM counter width; must be ≥ 4 + clog2(NUM_CH)
- BASE_ADDR, 4098, first word address of the register window

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- wren  in  1  data-memory write enable from the processor
- address  in  32  data-memory word address
- data_in  in  32  processor store data
- data_out  out  32  register read data; combinational
- rd_hit  out  1  high when `address` is inside the window; drives the wrapper's q_dmem mux
- audio_out  out  1  registered PWM audio output
- active  out  NUM_CH  per-channel "note sounding" flags, intended for LEDs

## Operation
Address map (offsets from BASE_ADDR; hit = offset < 2 + 2·NUM_CH):
- +0 CTRL, read/write: bit0 = global enable. Other bits read 0.
- +1 STATUS, read-only: [NUM_CH-1:0] = `active`. Writes are ignored.
- +2+2i PERIOD_i: [DIV_W-1:0] = half-period count P, [31:28] = volume V. Other bits read 0.
- +3+2i DUR_i: [15:0] = duration D in ms. Reads return the remaining ms.

Per-channel behaviour:
- active_i = enable & (P≠0) & (D_written==0 | remaining≠0).
- D_written==0 means sustain until P is written to 0.
- Writing PERIOD_i clears the phase counter and sets the phase low.
- Writing DUR_i loads remaining = D, clears the phase counter and sets the phase low. The note starts on the next cycle.
- Square wave: the counter runs 0..P-1. At P-1 it wraps to 0 and the phase toggles. Output frequency = SYS_FREQ / (2P).
- When a channel is inactive, its counter and phase are held at 0.
- ms tick: one-cycle pulse every SYS_FREQ/1000 cycles, from a free-running prescaler.
- On a tick, each active channel with remaining>0 decrements remaining. When remaining goes 1→0, the channel becomes inactive on that edge.
- While enable=0: prescaler and remaining counts freeze, and all phases are held low.

Mixer and PWM:
- mix = Σ (phase_i & active_i ? V_i : 0); width 4 + clog2(NUM_CH).
- duty = mix << (PWM_W − 4 − clog2(NUM_CH)).
- The PWM counter runs free over 0..2^PWM_W−1.
- The duty register is latched only when the PWM counter = 0, so the duty cannot glitch mid-period.
- audio_out <= (pwm_cnt < duty_reg).

## Timing
- Reset values: every register, counter, phase, duty_reg and the prescaler are 0; audio_out = 0; active = 0.
- data_out = 0 when rd_hit = 0.
- Writes take effect at the posedge where wren & hit.
- Reads are combinational in the same cycle, including read-after-write of the new value on the following cycle.
- Simultaneous DUR_i write and an expiring tick: the write wins (remaining = D, channel active).
- Simultaneous PERIOD_i write and phase wrap: the write wins (counter 0, phase low).
- P = 1 toggles the phase every cycle.
- Writing V = 0 keeps the channel active but silent.
- Reset asserted mid-note stops audio immediately (asynchronous). Output resumes only after fresh writes.
- Out-of-window addresses never modify state.

## Structure
- Package tone_pkg contains:
  - register offset constants: CTRL_OFF, STATUS_OFF, CH_BASE_OFF
  - the volume field position [31:28]
  - the DUR field width (16)
  - the helper function MIX_W(NUM_CH)
- Sub-module tone_channel, instantiated NUM_CH times via generate. It contains the period/volume/remaining registers, the phase counter and the active logic. Its inputs are write strobes, the tick and enable. Its outputs are the gated level and the read-back values.
- The top level contains the address decode, CTRL, prescaler, adder tree, PWM and the read mux.

## Test plan
Bench overrides: SYS_FREQ=10000 (tick every 10 cycles), NUM_CH=4, PWM_W=10.
- Reset, then read every offset → data_out=0, audio_out=0, active=0. Read address 5000 → rd_hit=0, data_out=0.
- CTRL=1; PERIOD_0 = V15, P=3; DUR_0=0 → phase_0 toggles every 3 cycles. While phase_0 is high, duty_reg = 15<<4 = 240 after the next PWM wrap. active=4'b0001 indefinitely.
- PERIOD_1 = V8, P=5; DUR_1=2 → active[1] high for 20 cycles (±1 tick alignment), then drops. DUR_1 reads back 2, 1, then 0.
- Write DUR_1=3 on the exact cycle its remaining goes 1→0 → channel stays active; remaining=3.
- All 4 channels at V15 with phases high → duty=960. Over one PWM period, audio_out is high for exactly 960 cycles.
- Pulse reset asynchronously mid-note → audio_out and active go 0 before the next clock edge. Write CTRL=0 during a note → remaining frozen and output silent. Restore CTRL=1 → the note resumes with the same remaining count.

Source files
------------

// File: rtl/tone_pkg.sv
// Register map offsets and field layout shared by the tone mixer and its channels.
package tone_pkg;

    // Word offsets from the base of the register window.
    localparam int CTRL_OFF    = 0;
    localparam int STATUS_OFF  = 1;
    localparam int CH_BASE_OFF = 2;

    // Volume nibble position inside the PERIOD word.
    localparam int VOL_MSB = 31;
    localparam int VOL_LSB = 28;
    localparam int VOL_W   = VOL_MSB - VOL_LSB + 1;

    // Width of the millisecond duration field in the DUR word.
    localparam int DUR_W = 16;

    // Mixer sum width: enough headroom for every channel at full volume.
    function automatic int MIX_W(input int num_ch);
        return VOL_W + $clog2(num_ch);
    endfunction

endpackage

// File: rtl/tone_channel.sv
// One square-wave tone voice: period/volume/duration registers, phase counter
// and the note-active logic.
module tone_channel
    import tone_pkg::*;
#(
    parameter int DIV_W = 24
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        tick,
    input  logic        period_we,
    input  logic        dur_we,
    input  logic [31:0] wdata,
    output logic        level,
    output logic        active,
    output logic [31:0] period_rd,
    output logic [31:0] dur_rd
);

    logic [DIV_W-1:0] period;
    logic [VOL_W-1:0] vol;
    logic             timed;
    logic [DUR_W-1:0] remaining;
    logic [DIV_W-1:0] cnt;
    logic             phase;
    logic             unused_wdata;

    // Only some fields of the store word are meaningful to a channel.
    assign unused_wdata = ^wdata;

    // A zero duration means the note sustains until the period is cleared.
    assign active = enable && (period != '0) && (!timed || (remaining != '0));
    assign level  = phase & active;

    // Period and volume are written together from one PERIOD word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            period <= '0;
            vol    <= '0;
        end else if (period_we) begin
            period <= wdata[DIV_W-1:0];
            vol    <= wdata[VOL_MSB:VOL_LSB];
        end
    end

    // Remaining note time; a DUR write outranks a tick that would expire the note.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timed     <= 1'b0;
            remaining <= '0;
        end else if (dur_we) begin
            timed     <= (wdata[DUR_W-1:0] != '0);
            remaining <= wdata[DUR_W-1:0];
        end else if (tick && active && (remaining != '0)) begin
            remaining <= remaining - 1'b1;
        end
    end

    // Half-period counter; any register write restarts the waveform low.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (period_we || dur_we || !active) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == period - 1'b1) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Read-back words, unused bits forced to zero.
    always_comb begin
        period_rd                  = '0;
        period_rd[DIV_W-1:0]       = period;
        period_rd[VOL_MSB:VOL_LSB] = vol;
        dur_rd                     = '0;
        dur_rd[DUR_W-1:0]          = remaining;
    end

endmodule

// File: rtl/mmio_tone_mixer.sv
// Memory-mapped multi-channel tone generator: address decode, global enable,
// millisecond prescaler, volume mixer and PWM audio output.
module mmio_tone_mixer
    import tone_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int SYS_FREQ  = 50000000,
    parameter int DIV_W     = 24,
    parameter int PWM_W     = 10,
    parameter int BASE_ADDR = 4098
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wren,
    input  logic [31:0]       address,
    input  logic [31:0]       data_in,
    output logic [31:0]       data_out,
    output logic              rd_hit,
    output logic              audio_out,
    output logic [NUM_CH-1:0] active
);

    localparam int          MX_W      = MIX_W(NUM_CH);
    localparam int          DUTY_SH   = PWM_W - MX_W;
    localparam int          TICK_DIV  = SYS_FREQ / 1000;
    localparam int          PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [31:0] NUM_WORDS = 32'(CH_BASE_OFF + 2 * NUM_CH);

    logic [31:0]       offset;
    logic              hit;
    logic              wr_hit;
    logic              enable;
    logic              tick;
    logic [PRE_W-1:0]  pre;
    logic [NUM_CH-1:0] level;
    logic [NUM_CH-1:0] period_we;
    logic [NUM_CH-1:0] dur_we;
    logic [31:0]       period_rd [NUM_CH];
    logic [31:0]       dur_rd    [NUM_CH];
    logic [MX_W-1:0]   mix;
    logic [PWM_W-1:0]  duty;
    logic [PWM_W-1:0]  duty_reg;
    logic [PWM_W-1:0]  pwm_cnt;

    // Addresses below the base wrap to huge offsets and miss.
    assign offset = address - 32'(BASE_ADDR);
    assign hit    = (offset < NUM_WORDS);
    assign rd_hit = hit;
    assign wr_hit = wren && hit;
    assign tick   = enable && (pre == PRE_W'(TICK_DIV - 1));

    // Global enable bit in CTRL.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            enable <= 1'b0;
        end else if (wr_hit && (offset == 32'(CTRL_OFF))) begin
            enable <= data_in[0];
        end
    end

    // Free-running millisecond prescaler, frozen while disabled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre <= '0;
        end else if (enable) begin
            if (tick) begin
                pre <= '0;
            end else begin
                pre <= pre + 1'b1;
            end
        end
    end

    // Per-channel write strobes decoded from the word offset.
    always_comb begin
        period_we = '0;
        dur_we    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            period_we[i] = wr_hit && (offset == 32'(CH_BASE_OFF + 2 * i));
            dur_we[i]    = wr_hit && (offset == 32'(CH_BASE_OFF + 2 * i + 1));
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tone_channel #(
            .DIV_W(DIV_W)
        ) u_ch (
            .clock    (clock),
            .reset    (reset),
            .enable   (enable),
            .tick     (tick),
            .period_we(period_we[i]),
            .dur_we   (dur_we[i]),
            .wdata    (data_in),
            .level    (level[i]),
            .active   (active[i]),
            .period_rd(period_rd[i]),
            .dur_rd   (dur_rd[i])
        );
    end

    // Sum the volumes of every channel whose square wave is currently high.
    always_comb begin
        mix = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (level[i]) begin
                mix = mix + MX_W'(period_rd[i][VOL_MSB:VOL_LSB]);
            end
        end
    end

    assign duty = PWM_W'(mix) << DUTY_SH;

    // PWM counter; duty is sampled only at the period start so a period never glitches.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pwm_cnt   <= '0;
            duty_reg  <= '0;
            audio_out <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (pwm_cnt == '0) begin
                duty_reg <= duty;
            end
            audio_out <= (pwm_cnt < duty_reg);
        end
    end

    // Combinational register read mux.
    always_comb begin
        data_out = '0;
        if (hit) begin
            if (offset == 32'(CTRL_OFF)) begin
                data_out[0] = enable;
            end
            if (offset == 32'(STATUS_OFF)) begin
                data_out[NUM_CH-1:0] = active;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (offset == 32'(CH_BASE_OFF + 2 * i)) begin
                    data_out = period_rd[i];
                end
                if (offset == 32'(CH_BASE_OFF + 2 * i + 1)) begin
                    data_out = dur_rd[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_mmio_tone_mixer.sv
// Directed bench for mmio_tone_mixer with a 10-cycle millisecond tick.
module tb_mmio_tone_mixer;

    localparam int NUM_CH   = 4;
    localparam int SYS_FREQ = 10000;
    localparam int DIV_W    = 24;
    localparam int PWM_W    = 10;
    localparam int BASE     = 4098;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              wren = 1'b0;
    logic [31:0]       address = 32'd0;
    logic [31:0]       data_in = 32'd0;
    logic [31:0]       data_out;
    logic              rd_hit;
    logic              audio_out;
    logic [NUM_CH-1:0] active;

    int tests_run    = 0;
    int tests_failed = 0;

    mmio_tone_mixer #(
        .NUM_CH   (NUM_CH),
        .SYS_FREQ (SYS_FREQ),
        .DIV_W    (DIV_W),
        .PWM_W    (PWM_W),
        .BASE_ADDR(BASE)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .wren     (wren),
        .address  (address),
        .data_in  (data_in),
        .data_out (data_out),
        .rd_hit   (rd_hit),
        .audio_out(audio_out),
        .active   (active)
    );

    always #5 clock = ~clock;

    task automatic bus_write(input int off, input logic [31:0] d);
        @(negedge clock);
        wren    = 1'b1;
        address = 32'(BASE + off);
        data_in = d;
        @(negedge clock);
        wren    = 1'b0;
        address = 32'd0;
        data_in = 32'd0;
    endtask

    task automatic bus_read(input int off, output logic [31:0] d);
        @(negedge clock);
        address = 32'(BASE + off);
        #1 d = data_out;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        for (int off = 0; off < 10; off++) begin
            bus_read(off, d);
            tests_run++;
            if (d !== 32'd0 || rd_hit !== 1'b1) begin
                tests_failed++;
                $display("FAIL reset_read off=%0d: got data=%h hit=%b, expected data=0 hit=1", off, d, rd_hit);
            end
        end
        tests_run++;
        if (audio_out !== 1'b0 || active !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_outputs: got audio=%b active=%b, expected 0 and 0000", audio_out, active);
        end
        address = 32'd5000;
        #1;
        tests_run++;
        if (rd_hit !== 1'b0 || data_out !== 32'd0) begin
            tests_failed++;
            $display("FAIL miss_5000: got hit=%b data=%h, expected hit=0 data=0", rd_hit, data_out);
        end
    endtask

    task automatic test_decode();
        logic [31:0] d;
        bus_write(1, 32'hFFFF_FFFF);
        bus_write(10, 32'hFFFF_FFFF);
        bus_write(-1, 32'hFFFF_FFFF);
        address = 32'(BASE + 10);
        #1;
        tests_run++;
        if (rd_hit !== 1'b0) begin
            tests_failed++;
            $display("FAIL window_edge_hit: got hit=%b, expected 0", rd_hit);
        end
        address = 32'(BASE - 1);
        #1;
        tests_run++;
        if (rd_hit !== 1'b0) begin
            tests_failed++;
            $display("FAIL below_base_hit: got hit=%b, expected 0", rd_hit);
        end
        for (int off = 0; off < 10; off++) begin
            bus_read(off, d);
            tests_run++;
            if (d !== 32'd0) begin
                tests_failed++;
                $display("FAIL ignored_write off=%0d: got %h, expected 0", off, d);
            end
        end
    endtask

    task automatic test_single_tone();
        logic [31:0] d;
        logic        prev;
        logic        cur;
        int          trans;
        int          bad;
        bit          seen;
        bus_write(0, 32'd1);
        bus_write(2, 32'hF000_0003);
        bus_write(3, 32'd0);
        bus_read(0, d);
        tests_run++;
        if (d !== 32'd1) begin
            tests_failed++;
            $display("FAIL ctrl_readback: got %h, expected 1", d);
        end
        bus_read(2, d);
        tests_run++;
        if (d !== 32'hF000_0003) begin
            tests_failed++;
            $display("FAIL period0_readback: got %h, expected f0000003", d);
        end
        bus_read(1, d);
        tests_run++;
        if (d !== 32'd1) begin
            tests_failed++;
            $display("FAIL status_one: got %h, expected 1", d);
        end
        prev  = dut.g_ch[0].u_ch.phase;
        trans = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clock);
            cur = dut.g_ch[0].u_ch.phase;
            if (cur != prev) trans++;
            prev = cur;
        end
        tests_run++;
        if (trans != 10) begin
            tests_failed++;
            $display("FAIL phase_toggles: got %0d toggles in 30 cycles, expected 10", trans);
        end
        bad  = 0;
        seen = 1'b0;
        for (int k = 0; k < 3200; k++) begin
            @(negedge clock);
            if (dut.duty_reg != 10'd0 && dut.duty_reg != 10'd240) bad++;
            if (dut.duty_reg == 10'd240) seen = 1'b1;
        end
        tests_run++;
        if (bad != 0 || seen != 1'b1) begin
            tests_failed++;
            $display("FAIL single_duty: got %0d bad samples seen240=%0d, expected 0 and 1", bad, seen);
        end
        tests_run++;
        if (active !== 4'b0001) begin
            tests_failed++;
            $display("FAIL sustain_active: got %b, expected 0001", active);
        end
    endtask

    task automatic test_timed_note();
        logic [31:0] vals [4];
        logic [31:0] last;
        int          nvals;
        int          n;
        bit          done;
        bus_write(4, 32'h8000_0005);
        bus_write(5, 32'd2);
        address = 32'(BASE + 5);
        nvals = 0;
        n     = 0;
        done  = 1'b0;
        last  = 32'd0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (nvals == 0 || data_out != last) begin
                if (nvals < 4) vals[nvals] = data_out;
                nvals++;
                last = data_out;
            end
            if (active[1]) n++;
            else begin
                done = 1'b1;
                break;
            end
            @(negedge clock);
        end
        tests_run++;
        if (!done || n < 10 || n > 20) begin
            tests_failed++;
            $display("FAIL timed_length: got %0d active cycles (ended=%0d), expected 10..20", n, done);
        end
        tests_run++;
        if (nvals != 3 || vals[0] !== 32'd2 || vals[1] !== 32'd1 || vals[2] !== 32'd0) begin
            tests_failed++;
            $display("FAIL dur_sequence: got %0d values starting %0d, expected 2,1,0", nvals, vals[0]);
        end
    endtask

    task automatic test_dur_collision();
        bit   found;
        logic tick_seen;
        bus_write(5, 32'd2);
        address = 32'(BASE + 5);
        found   = 1'b0;
        for (int k = 0; k < 30; k++) begin
            #1;
            if (data_out == 32'd1) begin
                found = 1'b1;
                break;
            end
            @(negedge clock);
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL collision_setup: remaining never reached 1, expected 1 within 30 cycles");
        end
        repeat (9) @(negedge clock);
        wren    = 1'b1;
        data_in = 32'd3;
        #1 tick_seen = dut.tick;
        @(negedge clock);
        wren    = 1'b0;
        data_in = 32'd0;
        #1;
        tests_run++;
        if (tick_seen !== 1'b1) begin
            tests_failed++;
            $display("FAIL collision_tick: got tick=%b on write cycle, expected 1", tick_seen);
        end
        tests_run++;
        if (active[1] !== 1'b1 || data_out !== 32'd3) begin
            tests_failed++;
            $display("FAIL collision_write_wins: got active=%b remaining=%0d, expected 1 and 3", active[1], data_out);
        end
        repeat (29) @(negedge clock);
        tests_run++;
        if (active[1] !== 1'b1) begin
            tests_failed++;
            $display("FAIL collision_hold: got active=%b after 29 cycles, expected 1", active[1]);
        end
        @(negedge clock);
        tests_run++;
        if (active[1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL collision_expire: got active=%b after 30 cycles, expected 0", active[1]);
        end
    endtask

    task automatic test_all_channels();
        logic [31:0] d;
        int          hi;
        for (int i = 0; i < NUM_CH; i++) bus_write(3 + 2 * i, 32'd0);
        for (int i = 0; i < NUM_CH; i++) bus_write(2 + 2 * i, 32'hF000_0BB8);
        repeat (3010) @(negedge clock);
        bus_read(1, d);
        tests_run++;
        if (d !== 32'h0000_000F) begin
            tests_failed++;
            $display("FAIL status_all: got %h, expected f", d);
        end
        repeat (1100) @(negedge clock);
        tests_run++;
        if (dut.duty_reg !== 10'd960) begin
            tests_failed++;
            $display("FAIL duty_all: got %0d, expected 960", dut.duty_reg);
        end
        hi = 0;
        for (int k = 0; k < 1024; k++) begin
            @(negedge clock);
            if (audio_out) hi++;
        end
        tests_run++;
        if (hi != 960) begin
            tests_failed++;
            $display("FAIL audio_high_all: got %0d high cycles, expected 960", hi);
        end
    endtask

    task automatic test_silent_volume();
        int hi;
        for (int i = 0; i < NUM_CH; i++) bus_write(2 + 2 * i, 32'h0000_0001);
        repeat (1100) @(negedge clock);
        tests_run++;
        if (active !== 4'b1111) begin
            tests_failed++;
            $display("FAIL silent_active: got %b, expected 1111", active);
        end
        hi = 0;
        for (int k = 0; k < 1024; k++) begin
            @(negedge clock);
            if (audio_out) hi++;
        end
        tests_run++;
        if (hi != 0) begin
            tests_failed++;
            $display("FAIL silent_audio: got %0d high cycles, expected 0", hi);
        end
    endtask

    task automatic test_enable_freeze();
        logic [31:0] r0;
        logic [31:0] r1;
        int          hi;
        int          n;
        bit          done;
        bus_write(6, 32'hF000_0004);
        bus_write(7, 32'd5);
        repeat (15) @(negedge clock);
        bus_write(0, 32'd0);
        bus_read(7, r0);
        tests_run++;
        if (r0 !== 32'd3 && r0 !== 32'd4) begin
            tests_failed++;
            $display("FAIL freeze_remaining: got %0d, expected 3 or 4", r0);
        end
        tests_run++;
        if (active !== 4'b0000) begin
            tests_failed++;
            $display("FAIL disabled_active: got %b, expected 0000", active);
        end
        repeat (50) @(negedge clock);
        bus_read(7, r1);
        tests_run++;
        if (r1 !== r0) begin
            tests_failed++;
            $display("FAIL frozen_count: got %0d, expected %0d", r1, r0);
        end
        repeat (1100) @(negedge clock);
        hi = 0;
        for (int k = 0; k < 1024; k++) begin
            @(negedge clock);
            if (audio_out) hi++;
        end
        tests_run++;
        if (hi != 0) begin
            tests_failed++;
            $display("FAIL disabled_audio: got %0d high cycles, expected 0", hi);
        end
        bus_write(0, 32'd1);
        address = 32'(BASE + 7);
        n    = 0;
        done = 1'b0;
        for (int k = 0; k < 70; k++) begin
            #1;
            if (k == 0) begin
                tests_run++;
                if (data_out !== r0 || active[2] !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL resume_state: got remaining=%0d active=%b, expected %0d and 1", data_out, active[2], r0);
                end
            end
            if (active[2]) n++;
            else begin
                done = 1'b1;
                break;
            end
            @(negedge clock);
        end
        tests_run++;
        if (!done || n < 10 * (int'(r0) - 1) + 1 || n > 10 * int'(r0)) begin
            tests_failed++;
            $display("FAIL resume_length: got %0d cycles (ended=%0d), expected %0d..%0d",
                     n, done, 10 * (int'(r0) - 1) + 1, 10 * int'(r0));
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        bit          found;
        int          hi;
        bus_write(2, 32'hF000_0FA0);
        bus_write(3, 32'd0);
        repeat (5110) @(negedge clock);
        found = 1'b0;
        for (int k = 0; k < 1100; k++) begin
            if (audio_out) begin
                found = 1'b1;
                break;
            end
            @(negedge clock);
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL prereset_audio: audio never high, expected a high pulse");
        end
        #2 reset = 1'b1;
        #1;
        tests_run++;
        if (audio_out !== 1'b0 || active !== 4'b0000) begin
            tests_failed++;
            $display("FAIL async_reset: got audio=%b active=%b, expected 0 and 0000", audio_out, active);
        end
        #1 reset = 1'b0;
        hi = 0;
        for (int k = 0; k < 1100; k++) begin
            @(negedge clock);
            if (audio_out) hi++;
        end
        tests_run++;
        if (hi != 0 || active !== 4'b0000) begin
            tests_failed++;
            $display("FAIL post_reset_quiet: got %0d high cycles active=%b, expected 0 and 0000", hi, active);
        end
        bus_read(0, d);
        tests_run++;
        if (d !== 32'd0) begin
            tests_failed++;
            $display("FAIL post_reset_ctrl: got %h, expected 0", d);
        end
        bus_read(2, d);
        tests_run++;
        if (d !== 32'd0) begin
            tests_failed++;
            $display("FAIL post_reset_period: got %h, expected 0", d);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_single_tone();
        test_timed_note();
        test_dur_collision();
        test_all_channels();
        test_silent_volume();
        test_enable_freeze();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
